// File: rtl/bf_pkg.sv
// Shared TinyBF definitions: 4-bit opcodes, loader state encoding, default terminator.
package bf_pkg;

  localparam logic [3:0] OP_END     = 4'd0;
  localparam logic [3:0] OP_INC_PTR = 4'd1;
  localparam logic [3:0] OP_DEC_PTR = 4'd2;
  localparam logic [3:0] OP_INC     = 4'd3;
  localparam logic [3:0] OP_DEC     = 4'd4;
  localparam logic [3:0] OP_OUT     = 4'd5;
  localparam logic [3:0] OP_IN      = 4'd6;
  localparam logic [3:0] OP_JMPF    = 4'd7;
  localparam logic [3:0] OP_JMPB    = 4'd8;

  localparam logic [7:0] TERM_CHAR_DEFAULT = 8'h21;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } ld_state_e;

  typedef struct packed {
    logic       is_cmd;
    logic       is_term;
    logic [3:0] opcode;
  } dec_t;

endpackage

// File: rtl/bf_char_decode.sv
// Combinational byte classifier: Brainfuck command -> opcode, terminator detect, else comment.
module bf_char_decode
  import bf_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = TERM_CHAR_DEFAULT
) (
  input  logic [7:0] byte_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (byte_i)
      8'h3E:   begin dec_o.is_cmd = 1'b1; dec_o.opcode = OP_INC_PTR; end
      8'h3C:   begin dec_o.is_cmd = 1'b1; dec_o.opcode = OP_DEC_PTR; end
      8'h2B:   begin dec_o.is_cmd = 1'b1; dec_o.opcode = OP_INC;     end
      8'h2D:   begin dec_o.is_cmd = 1'b1; dec_o.opcode = OP_DEC;     end
      8'h2E:   begin dec_o.is_cmd = 1'b1; dec_o.opcode = OP_OUT;     end
      8'h2C:   begin dec_o.is_cmd = 1'b1; dec_o.opcode = OP_IN;      end
      8'h5B:   begin dec_o.is_cmd = 1'b1; dec_o.opcode = OP_JMPF;    end
      8'h5D:   begin dec_o.is_cmd = 1'b1; dec_o.opcode = OP_JMPB;    end
      default: ;
    endcase
    // Terminator wins even if a non-default TERM_CHAR collides with a command.
    if (byte_i == TERM_CHAR || byte_i == 8'h00) begin
      dec_o.is_term = 1'b1;
      dec_o.is_cmd  = 1'b0;
    end
  end

endmodule

// File: rtl/bf_prog_loader.sv
// Upload sequencer: encodes received Brainfuck bytes into program memory, pads with END,
// checks bracket balance and reports done/error.
module bf_prog_loader
  import bf_pkg::*;
#(
  parameter int         ADDR_W    = 5,
  parameter int         INSTR_W   = 4,
  parameter logic [7:0] TERM_CHAR = 8'h21
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_mode_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [INSTR_W-1:0] mem_wdata_o,
  output logic              prog_busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   len_o
);

  // rx_valid_i is a one-cycle strobe with no ready: a byte is consumed in the cycle it is
  // valid (RECV only) or it is lost; mem_we_o is a one-cycle write strobe, no backpressure.

  localparam logic [ADDR_W:0]   PTR_FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] DEPTH_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] DEPTH_MAX = '1;

  ld_state_e          state_q;
  logic [ADDR_W:0]    wr_ptr_q;
  logic [ADDR_W-1:0]  depth_q;
  logic               err_q;
  logic               err_out_q;
  logic [ADDR_W:0]    len_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [INSTR_W-1:0] mem_wdata_q;
  logic               busy_q;
  logic               done_q;

  dec_t dec;
  logic term_err_d;
  logic end_recv_d;

  bf_char_decode #(.TERM_CHAR(TERM_CHAR)) u_decode (
    .byte_i (rx_data_i),
    .dec_o  (dec)
  );

  assign term_err_d = err_q | (depth_q != '0);
  // A falling prog_mode_i ends the upload and takes priority over a coincident byte.
  assign end_recv_d = !prog_mode_i || (rx_valid_i && dec.is_term);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      depth_q     <= '0;
      err_q       <= 1'b0;
      err_out_q   <= 1'b0;
      len_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (prog_mode_i) begin
            state_q  <= ST_RECV;
            busy_q   <= 1'b1;
            wr_ptr_q <= '0;
            depth_q  <= '0;
            err_q    <= 1'b0;
            len_q    <= '0;
          end
        end
        ST_RECV: begin
          if (end_recv_d) begin
            len_q <= wr_ptr_q;
            err_q <= term_err_d;
            if (wr_ptr_q == PTR_FULL) begin
              state_q   <= ST_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              err_out_q <= term_err_d;
            end else begin
              state_q <= ST_FILL;
            end
          end else if (rx_valid_i && dec.is_cmd) begin
            if (wr_ptr_q == PTR_FULL) begin
              err_q <= 1'b1;
            end else begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= wr_ptr_q[ADDR_W-1:0];
              mem_wdata_q <= INSTR_W'(dec.opcode);
              wr_ptr_q    <= wr_ptr_q + PTR_ONE;
              if (dec.opcode == OP_JMPF) begin
                if (depth_q != DEPTH_MAX) depth_q <= depth_q + DEPTH_ONE;
              end else if (dec.opcode == OP_JMPB) begin
                if (depth_q == '0) err_q <= 1'b1;
                else               depth_q <= depth_q - DEPTH_ONE;
              end
            end
          end
        end
        ST_FILL: begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= wr_ptr_q[ADDR_W-1:0];
          mem_wdata_q <= INSTR_W'(OP_END);
          wr_ptr_q    <= wr_ptr_q + PTR_ONE;
          if (wr_ptr_q[ADDR_W-1:0] == '1) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            err_out_q <= err_q;
          end
        end
        ST_DONE: begin
          if (!prog_mode_i) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            err_out_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign prog_busy_o = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_out_q;
  assign len_o       = len_q;

endmodule

// File: tb/tb_bf_prog_loader.sv
// Bench for bf_prog_loader: directed and random uploads against a byte-string reference model.
module tb_bf_prog_loader;

  localparam int AW = 5;
  localparam int IW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk_i       = 1'b0;
  logic          rst_i       = 1'b0;
  logic          prog_mode_i = 1'b0;
  logic          rx_valid_i  = 1'b0;
  logic [7:0]    rx_data_i   = 8'h00;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [IW-1:0] mem_wdata_o;
  logic          prog_busy_o;
  logic          done_o;
  logic          err_o;
  logic [AW:0]   len_o;

  int n_vec = 0;
  int n_err = 0;

  logic [AW+IW-1:0] exp_q[$];
  logic [7:0]       stim_q[$];
  int               exp_len;
  logic             exp_err;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bf_prog_loader #(.ADDR_W(AW), .INSTR_W(IW), .TERM_CHAR(8'h21)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .prog_mode_i (prog_mode_i),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .prog_busy_o (prog_busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .len_o       (len_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard: every write must match the next expected one ----------------
  always @(negedge clk_i) begin : mon
    logic [AW+IW-1:0] e;
    if (rst_i && mem_we_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", mem_we_o, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr_o, e[AW+IW-1:IW]);
        check("wr_data", mem_wdata_o, e[IW-1:0]);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int op_of(input logic [7:0] b);
    string cmds;
    cmds = "><+-.,[]";
    for (int i = 0; i < 8; i++)
      if (8'(cmds[i]) == b) return i + 1;
    return 0;
  endfunction

  // Walk the byte string: commands fill slots in order, a full memory or an unmatched ']'
  // flags an error, open brackets left at the end flag an error, the rest is END padding.
  task automatic model_upload(input bit pm_drop);
    int cnt = 0;
    int depth = 0;
    bit err = 0;
    int op;
    foreach (stim_q[i]) begin
      if (!pm_drop && (stim_q[i] == 8'h21 || stim_q[i] == 8'h00)) break;
      op = op_of(stim_q[i]);
      if (op != 0) begin
        if (cnt < DEPTH) begin
          exp_q.push_back({AW'(cnt), IW'(op)});
          cnt++;
          if (op == 7) depth++;
          if (op == 8) begin
            if (depth == 0) err = 1;
            else depth--;
          end
        end else begin
          err = 1;
        end
      end
    end
    if (depth != 0) err = 1;
    exp_len = cnt;
    exp_err = err;
    for (int a = cnt; a < DEPTH; a++) exp_q.push_back({AW'(a), IW'(0)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_str(input string s);
    stim_q.delete();
    for (int i = 0; i < s.len(); i++) stim_q.push_back(8'(s[i]));
  endtask

  function automatic logic [7:0] rand_body_byte();
    string cmds;
    logic [7:0] b;
    cmds = "><+-.,[]";
    if ($urandom_range(0, 9) < 7) return 8'(cmds[$urandom_range(0, 7)]);
    do b = 8'($urandom_range(1, 255)); while (op_of(b) != 0 || b == 8'h21);
    return b;
  endfunction

  // kind 0/1: stim_q ends with a terminator byte; kind 2: prog_mode_i falls with a coincident '+'
  task automatic drive_upload(input int kind);
    int t;
    model_upload(kind == 2);
    prog_mode_i = 1'b1;
    tick();
    check("busy_recv", prog_busy_o, 1'b1);
    foreach (stim_q[i]) begin
      rx_valid_i = 1'b1;
      rx_data_i  = stim_q[i];
      tick();
      rx_valid_i = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    if (kind == 2) begin
      prog_mode_i = 1'b0;
      rx_valid_i  = 1'b1;
      rx_data_i   = 8'h2B;
      tick();
      rx_valid_i = 1'b0;
    end
    t = 0;
    while (!done_o && t < 200) begin
      tick();
      t++;
    end
    check("done_seen", done_o, 1'b1);
    check("len", len_o, exp_len);
    check("err", err_o, exp_err);
    check("busy_done", prog_busy_o, 1'b0);
    @(negedge clk_i);
    #1;
    check("writes_left", exp_q.size(), 0);
    exp_q.delete();
    prog_mode_i = 1'b0;
    tick();
    check("done_clear", done_o, 1'b0);
    check("err_clear", err_o, 1'b0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    int n;

    #1;
    check("rst_we", mem_we_o, 1'b0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_wdata", mem_wdata_o, 0);
    check("rst_busy", prog_busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_len", len_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    tick();
    check("idle_busy", prog_busy_o, 1'b0);

    load_str("+[-].!");
    drive_upload(0);
    load_str("a+ b\n>!");
    drive_upload(0);
    load_str("]+!");
    drive_upload(0);
    load_str("[[+]!");
    drive_upload(0);
    stim_q.delete();
    for (int i = 0; i < 33; i++) stim_q.push_back(8'h2B);
    stim_q.push_back(8'h21);
    drive_upload(0);
    load_str("++");
    drive_upload(2);
    load_str("+>");
    stim_q.push_back(8'h00);
    drive_upload(1);
    load_str("!");
    drive_upload(0);

    // Reset in the middle of FILL: outputs drop at once, nothing else is written.
    load_str("+!");
    model_upload(0);
    prog_mode_i = 1'b1;
    tick();
    foreach (stim_q[i]) begin
      rx_valid_i = 1'b1;
      rx_data_i  = stim_q[i];
      tick();
    end
    rx_valid_i = 1'b0;
    repeat (3) tick();
    check("busy_fill", prog_busy_o, 1'b1);
    check("we_fill", mem_we_o, 1'b1);
    rst_i = 1'b0;
    #1;
    check("arst_we", mem_we_o, 1'b0);
    check("arst_addr", mem_addr_o, 0);
    check("arst_wdata", mem_wdata_o, 0);
    check("arst_busy", prog_busy_o, 1'b0);
    check("arst_done", done_o, 1'b0);
    check("arst_len", len_o, 0);
    exp_q.delete();
    prog_mode_i = 1'b0;
    #2 rst_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_valid_i = 1'b1;
      rx_data_i  = 8'h2B;
      tick();
      rx_valid_i = 1'b0;
      check("idle_busy_hold", prog_busy_o, 1'b0);
      check("idle_we_hold", mem_we_o, 1'b0);
      check("idle_done_hold", done_o, 1'b0);
    end

    // Random uploads with all three ways of ending.
    for (int u = 0; u < 25; u++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(0, 40);
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(rand_body_byte());
      if (kind == 0) stim_q.push_back(8'h21);
      if (kind == 1) stim_q.push_back(8'h00);
      drive_upload(kind);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bf_prog_loader.md
Name: bf_prog_loader

Overview:
- Upload sequencer for the TinyBF program memory.
- While programming mode is high it consumes received UART bytes, filters and encodes Brainfuck characters into 4-bit opcodes, and writes them to consecutive program-memory addresses.
- On completion it pads the unused memory with END, checks bracket balance, and reports done or error.
- Sits between the UART receiver and the program-memory write port inside bf_top; drives prog_busy_o.

Parameters:
- ADDR_W, 5, program memory address width (2^ADDR_W = 32 instructions).
- INSTR_W, 4, opcode width written to memory.
- TERM_CHAR, 8'h21, byte ('!') that terminates an upload.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous active-low reset.
- prog_mode_i  input  1  programming mode level (synchronised upstream).
- rx_valid_i  input  1  one-cycle strobe, rx_data_i valid.
- rx_data_i  input  8  received byte.
- mem_we_o  output  1  program memory write enable.
- mem_addr_o  output  ADDR_W  write address.
- mem_wdata_o  output  INSTR_W  opcode to write.
- prog_busy_o  output  1  high in RECV or FILL.
- done_o  output  1  upload finished (level, held in DONE).
- err_o  output  1  upload error (level, held in DONE).
- len_o  output  ADDR_W+1  number of opcodes written before padding.

Behaviour:
- Reset (async, rst_i=0) drives all outputs to 0 and enters IDLE. Counters, bracket depth and error flags are cleared.
- Opcode encoding: END=0, '>'=1, '<'=2, '+'=3, '-'=4, '.'=5, ','=6, '['=7, ']'=8. All other bytes except TERM_CHAR and 8'h00 are comments: dropped, with no write.
- States and transitions:
  - IDLE: on prog_mode_i=1, go to RECV. Clear wr_ptr (ADDR_W+1 bits), depth, err and len.
  - RECV: on rx_valid_i with a command byte, and wr_ptr < 2^ADDR_W:
    - Next cycle: mem_we_o=1, mem_addr_o=wr_ptr[ADDR_W-1:0], mem_wdata_o=opcode; wr_ptr increments. Write latency is exactly 1 cycle, registered.
    - '[' increments depth.
    - ']' with depth=0 sets err; otherwise decrements depth.
  - RECV, command byte with wr_ptr = 2^ADDR_W (full): no write; set err; stay in RECV.
  - RECV, TERM_CHAR, 8'h00, or prog_mode_i falling: latch len_o=wr_ptr; set err if depth≠0; go to FILL.
  - RECV, prog_mode_i falling and rx_valid_i in the same cycle: prog_mode_i wins and the byte is dropped.
  - FILL: one END write per cycle at wr_ptr, incrementing, until wr_ptr = 2^ADDR_W, then go to DONE. If len=2^ADDR_W, FILL lasts 0 cycles: go to DONE directly, with no writes.
  - FILL ignores rx_valid_i and prog_mode_i.
  - DONE: done_o=1; err_o holds the error flag. When prog_mode_i=0, go to IDLE, clearing done_o and err_o on the cycle of exit.
  - IDLE with rx_valid_i: ignored.
- prog_busy_o is registered and equals (state==RECV || state==FILL).
- Only one write can occur per cycle: the RECV write and FILL writes never overlap, because FILL is entered after the last RECV write has issued.
- Reset mid-upload aborts immediately. Memory contents are left partially written, with no padding.
- depth saturates at 2^ADDR_W-1. Overflow is impossible because depth ≤ wr_ptr.

Decomposition:
- Package bf_pkg: opcode localparams (OP_END..OP_JMPB), the state encoding, and TERM_CHAR default.
- Sub-module bf_char_decode (combinational): byte → {is_cmd, is_term, opcode}. It is shared with any future decoder.
- The FSM, counters and write register live in bf_prog_loader.

Test Plan:
- Upload "+[-]." then '!' → writes at addresses 0..4 of 3,7,4,8,5; then 27 END writes at 5..31; len_o=5, done_o=1, err_o=0, prog_busy_o low after the last write.
- Upload "a+ b\n>!" → only 3 at addr 0 and 1 at addr 1; comments produce no mem_we_o; len_o=2.
- Upload "]+!" → err_o=1 at DONE. Also "[[+]!" → err_o=1 (depth 1 at termination).
- 33 '+' bytes then '!' → 32 writes at 0..31, 33rd byte sets err; FILL takes 0 cycles; len_o=32, err_o=1.
- "++" then prog_mode_i falls, with a coincident rx_valid_i '+' → byte dropped, len_o=2, FILL writes END at 2..31, done_o=1; done_o clears on the next cycle in IDLE.
- Assert rst_i=0 mid-FILL → all outputs 0 asynchronously; after release the block stays in IDLE until prog_mode_i=1.
